data_memory: RTL and testbench

// - Data memory of the single-cycle processor, accessed by load/store instructions.
// - Byte-addressed, doubleword-wide (64-bit) storage.
// - Synchronous write, synchronous registered read.
// - Sits after the ALU: Address = ALU result, WriteData = register-file read port 2,

---
 rtl/data_memory.sv | 93 +++++++++
 tb/tb_data_memory.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/data_memory.sv
// ---------------------------------------------------------------------------
// data_memory
//
// Data memory of the single-cycle processor, used by load/store instructions.
// The store is byte-addressed, DEPTH words of DATA_W bits each. Writes are
// synchronous. Reads are synchronous and registered: ReadData is updated at
// the read edge and then holds until the next read or reset.
//
// Ports
//   Clock        in   1       single clock, rising edge active
//   Reset        in   1       asynchronous, active-high; clears ReadData and
//                             every memory word
//   Address      in   ADDR_W  byte address; word index = Address[3 +: log2(DEPTH)],
//                             Address[2:0] ignored, higher bits must be zero
//   WriteData    in   DATA_W  data stored on a write
//   EnableWrite  in   1       write strobe
//   EnableRead   in   1       read strobe
//   ReadData     out  DATA_W  registered read result
//
// Configuration
//   DATAMEM_BYPASS_EN  defined   : write-first. A read and a write in the same
//                                  cycle load ReadData with WriteData.
//                      undefined : read-first (default). ReadData gets the
//                                  word's old contents.
//   A simultaneous read and write always target the same word, because both
//   use the single Address port.
// ---------------------------------------------------------------------------
module data_memory #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64,
  parameter int DEPTH  = 128
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] Address,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              EnableWrite,
  input  logic              EnableRead,
  output logic [DATA_W-1:0] ReadData
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int HI_LO = 3 + IDX_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_d;
  logic [IDX_W-1:0]  idx;
  logic              in_range;
  logic              unused_addr_lo;

  assign idx = Address[3 +: IDX_W];

  // An address is in range only if every bit above the word index is zero.
  assign in_range = (Address[ADDR_W-1:HI_LO] == '0);

  // The byte offset within a doubleword plays no part in addressing.
  assign unused_addr_lo = ^Address[2:0];

  always_comb begin
    rdata_d = rdata_q;
    if (EnableRead) begin
      if (!in_range) begin
        rdata_d = '0;
      end else begin
        rdata_d = mem_q[idx];
`ifdef DATAMEM_BYPASS_EN
        // Write-first: a same-cycle write is forwarded to the read result.
        if (EnableWrite) begin
          rdata_d = WriteData;
        end
`endif
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      rdata_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      rdata_q <= rdata_d;
      if (EnableWrite && in_range) begin
        mem_q[idx] <= WriteData;
      end
    end
  end

  assign ReadData = rdata_q;

endmodule

// File: tb/tb_data_memory.sv
module tb_data_memory;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 64;
  localparam int DEPTH  = 128;

  logic              Clock;
  logic              Reset;
  logic [ADDR_W-1:0] Address;
  logic [DATA_W-1:0] WriteData;
  logic              EnableWrite;
  logic              EnableRead;
  logic [DATA_W-1:0] ReadData;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: plain array of words plus the expected read register.
  logic [DATA_W-1:0] ref_mem [DEPTH];
  logic [DATA_W-1:0] ref_rd;

  data_memory #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .Address     (Address),
    .WriteData   (WriteData),
    .EnableWrite (EnableWrite),
    .EnableRead  (EnableRead),
    .ReadData    (ReadData)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [DATA_W-1:0] got,
                     input logic [DATA_W-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic ref_clear();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    ref_rd = '0;
  endtask

  // One clock edge of stimulus. The model applies the rules in terms of
  // byte address arithmetic: word = addr / 8, valid only if addr < DEPTH*8.
  task automatic cycle(input string tag, input logic we, input logic re,
                       input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wd);
    logic              inr;
    int                w;
    logic [DATA_W-1:0] old;
    @(negedge Clock);
    Address = addr; WriteData = wd; EnableWrite = we; EnableRead = re;
    inr = (addr < 64'(DEPTH * 8));
    w   = inr ? int'(addr / 8) : 0;
    old = ref_mem[w];
    if (re) begin
      if (!inr) ref_rd = '0;
`ifdef DATAMEM_BYPASS_EN
      else if (we) ref_rd = wd;
`endif
      else ref_rd = old;
    end
    if (we && inr) ref_mem[w] = wd;
    @(posedge Clock);
    #1;
    chk(tag, ReadData, ref_rd);
  endtask

  task automatic pulse_reset();
    @(negedge Clock);
    #2;
    Reset = 1'b1;
    #1;
    ref_clear();
    chk("reset_immediate", ReadData, '0);
    // Strobes during reset must be ignored.
    EnableWrite = 1'b1; EnableRead = 1'b1;
    Address = 64'h10; WriteData = 64'hFFFF_FFFF_FFFF_FFFF;
    @(posedge Clock);
    #1;
    chk("reset_hold", ReadData, '0);
    @(negedge Clock);
    EnableWrite = 1'b0; EnableRead = 1'b0;
    Reset = 1'b0;
  endtask

  initial begin
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic              we, re;
    Reset = 1'b1; Address = '0; WriteData = '0;
    EnableWrite = 1'b0; EnableRead = 1'b0;
    ref_clear();
    #3;
    chk("reset_state", ReadData, '0);
    @(negedge Clock);
    Reset = 1'b0;

    // Write, then read, then hold.
    cycle("wr_10", 1, 0, 64'h10, 64'hDEADBEEFCAFEBABE);
    chk("no_read_yet", ReadData, '0);
    cycle("rd_10", 0, 1, 64'h10, '0);
    chk("rd_10_const", ReadData, 64'hDEADBEEFCAFEBABE);
    cycle("hold", 0, 0, 64'h10, '0);
    chk("hold_const", ReadData, 64'hDEADBEEFCAFEBABE);
    cycle("reread_17", 0, 1, 64'h17, '0);
    chk("reread_const", ReadData, 64'hDEADBEEFCAFEBABE);

    // Overwrite.
    cycle("ovw_wr", 1, 0, 64'h10, 64'h1122334455667788);
    cycle("ovw_rd", 0, 1, 64'h10, '0);
    chk("ovw_const", ReadData, 64'h1122334455667788);

    // Out-of-range write leaves memory unchanged; read returns 0.
    cycle("oor_wr", 1, 0, 64'h1_0000_0010, 64'h5555);
    cycle("oor_rd", 0, 1, 64'h1_0000_0000, '0);
    chk("oor_rd_const", ReadData, '0);
    cycle("after_oor", 0, 1, 64'h10, '0);
    chk("after_oor_const", ReadData, 64'h1122334455667788);
    cycle("oor_top", 0, 1, 64'(DEPTH * 8), '0);
    cycle("last_wr", 1, 0, 64'(DEPTH * 8 - 1), 64'h77);
    cycle("last_rd", 0, 1, 64'(DEPTH * 8 - 8), '0);
    chk("last_const", ReadData, 64'h77);

    // Reset clears memory.
    pulse_reset();
    cycle("post_rst_rd", 0, 1, 64'h10, '0);
    chk("post_rst_const", ReadData, '0);

    // Simultaneous read and write.
    cycle("sim_pre", 1, 0, 64'h18, 64'hAA);
    cycle("sim_rw", 1, 1, 64'h18, 64'hBB);
`ifdef DATAMEM_BYPASS_EN
    chk("sim_const", ReadData, 64'hBB);
`else
    chk("sim_const", ReadData, 64'hAA);
`endif
    cycle("sim_after", 0, 1, 64'h18, '0);
    chk("sim_after_const", ReadData, 64'hBB);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      we = ($urandom_range(0, 99) < 45);
      re = ($urandom_range(0, 99) < 45);
      if ($urandom_range(0, 9) == 0)
        a = {$urandom, $urandom} | 64'(DEPTH * 8);
      else
        a = 64'($urandom_range(0, 15) * 8 + $urandom_range(0, 7));
      d = {$urandom, $urandom};
      cycle("rand", we, re, a, d);
      if (i == 300) pulse_reset();
    end

    // Sweep every word: write distinct patterns, read back.
    for (int i = 0; i < DEPTH; i++)
      cycle("sweep_wr", 1, 0, 64'(i * 8), {32'(i), ~32'(i)});
    for (int i = 0; i < DEPTH; i++)
      cycle("sweep_rd", 0, 1, 64'(i * 8 + (i % 8)), '0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
